// File: rtl/addac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addac_pkg
// Brief   : Shared types and constants for the addac4 command sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package addac_pkg;

  // Datapath operand / result width
  localparam int DW = 4;

  // Datapath select code {sel1,sel0}
  typedef logic [1:0] op_t;

  // Sequencer states, explicitly encoded on 3 bits
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/addac_seq.sv
`default_nettype none
// ============================================================================
// Module  : addac_seq
// Brief   : Command/response sequencer for an external addac4 datapath.
//           A command sets up operand and select, issues one registered
//           dp_iclk pulse, waits SETTLE_CYC cycles and captures S/carry.
//           Optional: define ADDAC_SEQ_OVF_EN to add the saturating ovf_cnt
//           output counting captures that saw dp_cout=1.
// Revision: 1.0 - initial release
// ============================================================================
module addac_seq
  import addac_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_cout,
  output logic          busy,
  output logic [DW-1:0] dp_a,
  output logic          dp_sel0,
  output logic          dp_sel1,
  output logic          dp_iclk,
  input  logic [DW-1:0] dp_s,
  input  logic          dp_cout
`ifdef ADDAC_SEQ_OVF_EN
  ,
  output logic [7:0]    ovf_cnt
`endif
);

  // Settle length loaded into the 4-bit down-counter
  localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYC);

  state_e        r_state;
  logic [DW-1:0] r_a;
  op_t           r_sel;
  logic          r_iclk;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_sum;
  logic          r_cout;
  logic          w_capture;

  // The last SETTLE cycle is the one whose closing edge samples the datapath
  assign w_capture = (r_state == SETTLE) && (r_cnt == 4'd1);

  // Sequencer FSM with all datapath-facing outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_sel   <= '0;
      r_iclk  <= 1'b0;
      r_cnt   <= 4'd0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_a     <= cmd_data;
            r_sel   <= cmd_op;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_iclk  <= 1'b1;
          r_state <= PULSE;
        end
        PULSE: begin
          r_iclk  <= 1'b0;
          r_cnt   <= c_SETTLE;
          r_state <= SETTLE;
        end
        SETTLE: begin
          if (w_capture) begin
            r_sum   <= dp_s;
            r_cout  <= dp_cout;
            r_cnt   <= 4'd0;
            r_sel   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_iclk  <= 1'b0;
          r_sel   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDAC_SEQ_OVF_EN
  logic [7:0] r_ovf;

  // Saturating count of captures that carried out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 8'd0;
    end else if (w_capture && dp_cout && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf;
`endif

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign dp_a      = r_a;
  assign dp_sel0   = r_sel[0];
  assign dp_sel1   = r_sel[1];
  assign dp_iclk   = r_iclk;

endmodule
`default_nettype wire

// File: doc/addac_seq.md
ADDAC_SEQ -- requirements
Module: addac_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 1, number of cycles after the datapath clock pulse before the result is captured (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_op (input, 2, datapath select code {sel1,sel0}) and cmd_data (input, 4, operand A).
REQ-005 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_sum (output, 4, captured S) and rsp_cout (output, 1, captured carry).
REQ-006 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 The block SHALL have datapath-side ports dp_a (output, 4), dp_sel0 (output, 1), dp_sel1 (output, 1), dp_iclk (output, 1), dp_s (input, 4) and dp_cout (input, 1), all driving or observing one addac4 instance.

Function
REQ-008 The FSM SHALL have states IDLE, SETUP, PULSE, SETTLE and RESP; cmd_ready SHALL be high only in IDLE.
REQ-009 A command SHALL be accepted at the rising edge where cmd_valid and cmd_ready are both high (edge T); the FSM SHALL then enter SETUP.
REQ-010 SETUP (cycle T+1) SHALL drive dp_a=cmd_data and {dp_sel1,dp_sel0}=cmd_op, both registered at T, with dp_iclk=0.
REQ-011 PULSE (cycle T+2) SHALL drive dp_iclk=1 for exactly one cycle, keeping dp_a and the selects stable.
REQ-012 SETTLE SHALL last SETTLE_CYC cycles with dp_iclk=0, counted by a 4-bit down-counter; dp_s and dp_cout SHALL be registered into rsp_sum and rsp_cout at the edge that ends the last SETTLE cycle.
REQ-013 RESP SHALL assert rsp_valid from cycle T+3+SETTLE_CYC, holding rsp_sum and rsp_cout stable until the rsp_valid&&rsp_ready edge, after which the FSM SHALL return to IDLE.
REQ-014 In IDLE and RESP, dp_sel0/dp_sel1 SHALL be 0 and dp_iclk SHALL be 0; dp_a SHALL hold its last value.
REQ-015 Back-to-back throughput SHALL be one command per 4+SETTLE_CYC cycles with rsp_ready and cmd_valid held high.
REQ-016 A cmd_valid arriving while busy SHALL be ignored (not latched); the command SHALL be taken only once IDLE is reached.
REQ-017 dp_iclk SHALL be a registered output, glitch-free, and SHALL never be high in two consecutive cycles.

Reset
REQ-018 When rst is high at an edge, the FSM SHALL go to IDLE, and cmd_ready=1, rsp_valid=0, busy=0, dp_iclk=0, dp_sel0=dp_sel1=0, dp_a=0, rsp_sum=0, rsp_cout=0 and the settle counter=0.
REQ-019 A reset during SETUP, PULSE, SETTLE or RESP SHALL abort the command with no response; if dp_iclk was high it SHALL be low in the cycle after the reset edge.

Configuration
REQ-020 With ADDAC_SEQ_OVF_EN defined, the block SHALL add output port ovf_cnt (8 bits), a saturating count (stops at 255) of captures with dp_cout=1, cleared by rst.
REQ-021 Without ADDAC_SEQ_OVF_EN, the block SHALL omit the ovf_cnt port and counter, with all other behaviour identical.

Structure
REQ-022 Package addac_pkg SHALL hold the state enum (IDLE, SETUP, PULSE, SETTLE, RESP), the op-code typedef (2 bits) and the width constant DW=4.
REQ-023 The block SHALL contain no sub-module; the addac4 datapath SHALL be instantiated by the parent and by the bench, connected through the dp_* ports.

Verification
REQ-024 The bench SHALL cover: rst high 3 cycles then low -> cmd_ready=1, rsp_valid=0, all dp_* = 0.
REQ-025 The bench SHALL cover: cmd_op=2'b01, cmd_data=4'b0101, SETTLE_CYC=1, rsp_ready=1 -> dp_iclk high only in cycle T+2, rsp_valid in T+4, rsp_sum equal to the addac4 output S at capture.
REQ-026 The bench SHALL cover: back-to-back commands with rsp_ready=1 and SETTLE_CYC=3 -> acceptances exactly 7 cycles apart.
REQ-027 The bench SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_sum stable, cmd_ready=0, no dp_iclk pulse.
REQ-028 The bench SHALL cover: rst asserted during PULSE -> next cycle dp_iclk=0, IDLE, and no rsp_valid.
REQ-029 With ADDAC_SEQ_OVF_EN, the bench SHALL cover: 300 captures with dp_cout forced to 1 -> ovf_cnt=255.
